// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential MIPS DIV/DIVU controller.
// Holds FSM state encodings, the EX-stage result bundle and a sign helper.
package div_seq_ctrl_pkg;

    localparam int WIDTH      = 32;
    localparam int DIV_CYCLES = WIDTH;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_BUSY = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Result bundle handed back to the EX stage.
    typedef struct packed {
        logic             ready;
        logic             hi_we;
        logic             lo_we;
        logic [WIDTH-1:0] remainder;
        logic [WIDTH-1:0] quotient;
    } div_to_ex_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX-stage <-> divider bundle: operands and control in, stall/result/write enables out.
// The pipeline drives through master, the divider sits on slave.
interface div_seq_ctrl_if;
    import div_seq_ctrl_pkg::*;

    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stallreq;
    logic             ready;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, annul, dividend, divisor,
        input  stallreq, ready, hi_we, lo_we, quotient, remainder
    );

    modport slave (
        input  start, signed_div, annul, dividend, divisor,
        output stallreq, ready, hi_we, lo_we, quotient, remainder
    );

endinterface

// File: rtl/div_seq_ctrl_step.sv
// One combinational restoring-division step on a 2*WIDTH partial remainder.
// Shifts left by one and subtracts the divisor from the upper half when it fits.
module div_seq_ctrl_step
    import div_seq_ctrl_pkg::*;
(
    input  logic [2*WIDTH-1:0] pr,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] pr_next
);

    logic [WIDTH:0]   upper;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // Upper half after the shift needs one extra bit to hold the carried-out MSB.
        upper = pr[2*WIDTH-1:WIDTH-1];
        diff  = upper[WIDTH-1:0] - divisor;
        if (upper >= {1'b0, divisor}) begin
            pr_next = {diff, pr[WIDTH-2:0], 1'b1};
        end else begin
            pr_next = {pr[2*WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the shared 32-cycle restoring divider used by MIPS DIV/DIVU in EX.
// Latches operands, iterates one quotient bit per cycle, sign-corrects, and writes HI/LO.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);

    div_state_e         state;
    div_state_e         state_next;
    logic [2*WIDTH-1:0] pr;
    logic [2*WIDTH-1:0] pr_step;
    logic [WIDTH-1:0]   divisor_abs;
    logic [CNT_W-1:0]   count;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               launch;
    logic               last_step;
    logic               stallreq;
    logic               ready;
    div_to_ex_t         to_ex;

    assign launch    = bus.start & ~bus.annul;
    assign last_step = (count == CNT_W'(DIV_CYCLES - 1));

    div_seq_ctrl_step u_step (
        .pr      (pr),
        .divisor (divisor_abs),
        .pr_next (pr_step)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        stallreq   = 1'b0;
        ready      = 1'b0;
        case (state)
            DIV_IDLE: begin
                stallreq = launch;
                if (launch) begin
                    state_next = (bus.divisor == '0) ? DIV_ZERO : DIV_BUSY;
                end
            end
            DIV_ZERO: begin
                stallreq   = ~bus.annul;
                state_next = bus.annul ? DIV_IDLE : DIV_DONE;
            end
            DIV_BUSY: begin
                stallreq = ~bus.annul;
                if (bus.annul) begin
                    state_next = DIV_IDLE;
                end else if (last_step) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // Same instruction is still in EX here, so start is deliberately ignored.
                ready      = ~bus.annul;
                state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    // NOTE: working registers carry no reset; they are always loaded at launch before being read.
    always_ff @(posedge clk) begin
        case (state)
            DIV_IDLE: begin
                if (launch) begin
                    // Divide-by-zero reports the raw dividend, so skip the magnitude there.
                    pr          <= {{WIDTH{1'b0}}, (bus.divisor == '0) ? bus.dividend
                                                   : magnitude(bus.dividend, bus.signed_div)};
                    divisor_abs <= magnitude(bus.divisor, bus.signed_div);
                    neg_q       <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    neg_r       <= bus.signed_div & bus.dividend[WIDTH-1];
                    count       <= '0;
                end
            end
            DIV_BUSY: begin
                pr    <= pr_step;
                count <= count + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Results are visible from DONE onward and hold until the next completed op.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (state == DIV_BUSY && last_step && !bus.annul) begin
            quotient  <= neg_q ? -pr_step[WIDTH-1:0] : pr_step[WIDTH-1:0];
            remainder <= neg_r ? -pr_step[2*WIDTH-1:WIDTH] : pr_step[2*WIDTH-1:WIDTH];
        end else if (state == DIV_ZERO && !bus.annul) begin
            quotient  <= '1;
            remainder <= pr[WIDTH-1:0];
        end
    end

    assign to_ex = '{ready: ready, hi_we: ready, lo_we: ready,
                     remainder: remainder, quotient: quotient};

    assign bus.stallreq  = stallreq;
    assign bus.ready     = to_ex.ready;
    assign bus.hi_we     = to_ex.hi_we;
    assign bus.lo_we     = to_ex.lo_we;
    assign bus.quotient  = to_ex.quotient;
    assign bus.remainder = to_ex.remainder;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, signed fixes, div-by-zero, annul, back-to-back, reset.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_div_seq_ctrl;
    import div_seq_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    div_seq_ctrl_if bus ();

    div_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
    endtask

    // Runs max_cyc cycles starting from the current one and reports what was seen.
    task automatic observe(input int max_cyc, input logic drop_start,
                           output int ready_cnt, output int ready_at, output int stall_end,
                           output logic stall_gap, output logic we_ok, output logic held,
                           output logic [31:0] q, output logic [31:0] r);
        logic [31:0] q0;
        logic [31:0] r0;
        ready_cnt = 0; ready_at = -1; stall_end = -1;
        stall_gap = 1'b0; we_ok = 1'b1; held = 1'b1; q = '0; r = '0; q0 = '0; r0 = '0;
        for (int c = 0; c < max_cyc; c++) begin
            #1;
            if (c == 0) begin q0 = bus.quotient; r0 = bus.remainder; end
            if (ready_at < 0 && bus.ready !== 1'b1 &&
                (bus.quotient !== q0 || bus.remainder !== r0)) held = 1'b0;
            if (bus.hi_we !== bus.ready || bus.lo_we !== bus.ready) we_ok = 1'b0;
            if (bus.stallreq === 1'b1) begin
                if (c != stall_end + 1) stall_gap = 1'b1;
                stall_end = c;
            end else if (bus.stallreq !== 1'b0) begin
                stall_gap = 1'b1;
            end
            if (bus.ready === 1'b1) begin
                ready_cnt++;
                if (ready_at < 0) begin
                    ready_at = c; q = bus.quotient; r = bus.remainder;
                    if (drop_start) bus.start = 1'b0;
                end
            end
            next_cycle();
        end
    endtask

    // Full single operation with its own inline expectations.
    task automatic test_op(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input logic [31:0] exp_q, input logic [31:0] exp_r);
        int cnt, at, se;
        logic gap, we, hld;
        logic [31:0] q, r;
        drive(sgn, a, b);
        observe(exp_lat + 6, 1'b1, cnt, at, se, gap, we, hld, q, r);
        bus.start = 1'b0;
        total++; if (at !== exp_lat) begin bad++; $display("FAIL %s ready_cycle got=%0d want=%0d", name, at, exp_lat); end
        total++; if (cnt !== 1) begin bad++; $display("FAIL %s ready_pulses got=%0d want=1", name, cnt); end
        total++; if (se !== exp_lat - 1 || gap !== 1'b0) begin bad++; $display("FAIL %s stall_end got=%0d gap=%0b want=%0d gap=0", name, se, gap, exp_lat - 1); end
        total++; if (we !== 1'b1) begin bad++; $display("FAIL %s hi_lo_we got=%0b want=1", name, we); end
        total++; if (q !== exp_q) begin bad++; $display("FAIL %s quotient got=%h want=%h", name, q, exp_q); end
        total++; if (r !== exp_r) begin bad++; $display("FAIL %s remainder got=%h want=%h", name, r, exp_r); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
        bus.dividend = '0; bus.divisor = '0;
        repeat (3) next_cycle();
        #1;
        total++; if (bus.stallreq !== 1'b0 || bus.ready !== 1'b0) begin bad++; $display("FAIL reset stall_ready got=%b%b want=00", bus.stallreq, bus.ready); end
        total++; if (bus.hi_we !== 1'b0 || bus.lo_we !== 1'b0) begin bad++; $display("FAIL reset we got=%b%b want=00", bus.hi_we, bus.lo_we); end
        total++; if (bus.quotient !== '0 || bus.remainder !== '0) begin bad++; $display("FAIL reset results got=%h/%h want=0/0", bus.quotient, bus.remainder); end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_unsigned();
        test_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        test_op("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    endtask

    task automatic test_signed();
        test_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        test_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        test_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    endtask

    task automatic test_divzero();
        test_op("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, 32'd5);
    endtask

    task automatic test_annul();
        int cnt, at, se;
        logic gap, we, hld;
        logic [31:0] q, r;
        drive(1'b0, 32'd1000, 32'd3);
        repeat (10) next_cycle();
        bus.annul = 1'b1;
        #1;
        total++; if (bus.stallreq !== 1'b0 || bus.ready !== 1'b0) begin bad++; $display("FAIL annul_cycle stall_ready got=%b%b want=00", bus.stallreq, bus.ready); end
        next_cycle();
        bus.annul = 1'b0; bus.start = 1'b0;
        observe(40, 1'b1, cnt, at, se, gap, we, hld, q, r);
        total++; if (cnt !== 0 || se !== -1) begin bad++; $display("FAIL annul_after ready_cnt=%0d stall_end=%0d want=0/-1", cnt, se); end
        total++; if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd5) begin bad++; $display("FAIL annul_hold got=%h/%h want=ffffffff/00000005", bus.quotient, bus.remainder); end
        // annul must win over start while idle
        drive(1'b0, 32'd9, 32'd3);
        bus.annul = 1'b1;
        #1;
        total++; if (bus.stallreq !== 1'b0) begin bad++; $display("FAIL annul_idle stallreq got=%b want=0", bus.stallreq); end
        next_cycle();
        bus.annul = 1'b0; bus.start = 1'b0;
        observe(5, 1'b1, cnt, at, se, gap, we, hld, q, r);
        total++; if (cnt !== 0 || se !== -1) begin bad++; $display("FAIL annul_idle_after ready_cnt=%0d stall_end=%0d want=0/-1", cnt, se); end
        test_op("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);
    endtask

    task automatic test_back_to_back();
        int cnt, at, se;
        logic gap, we, hld;
        logic [31:0] q, r;
        drive(1'b0, 32'd50, 32'd5);
        observe(34, 1'b0, cnt, at, se, gap, we, hld, q, r);
        total++; if (cnt !== 1 || at !== 33) begin bad++; $display("FAIL b2b_first ready_cnt=%0d at=%0d want=1/33", cnt, at); end
        total++; if (q !== 32'd10 || r !== 32'd0) begin bad++; $display("FAIL b2b_first result got=%h/%h want=0000000a/00000000", q, r); end
        // start still high: the IDLE cycle right after DONE launches the next op
        drive(1'b0, 32'd77, 32'd10);
        observe(40, 1'b1, cnt, at, se, gap, we, hld, q, r);
        bus.start = 1'b0;
        total++; if (cnt !== 1 || at !== 33 || se !== 32) begin bad++; $display("FAIL b2b_second ready_cnt=%0d at=%0d stall_end=%0d want=1/33/32", cnt, at, se); end
        total++; if (hld !== 1'b1) begin bad++; $display("FAIL b2b_hold outputs_held=%b want=1", hld); end
        total++; if (q !== 32'd7 || r !== 32'd7) begin bad++; $display("FAIL b2b_second result got=%h/%h want=00000007/00000007", q, r); end
    endtask

    task automatic test_mid_reset();
        int cnt, at, se;
        logic gap, we, hld;
        logic [31:0] q, r;
        drive(1'b0, 32'd1000, 32'd3);
        repeat (15) next_cycle();
        rst = 1'b1;
        #1;
        total++; if (bus.stallreq !== 1'b1) begin bad++; $display("FAIL rst_busy stallreq got=%b want=1", bus.stallreq); end
        next_cycle();
        rst = 1'b0; bus.start = 1'b0;
        #1;
        total++; if (bus.stallreq !== 1'b0 || bus.ready !== 1'b0 || bus.hi_we !== 1'b0 || bus.lo_we !== 1'b0) begin bad++; $display("FAIL rst_mid ctrl got=%b%b%b%b want=0000", bus.stallreq, bus.ready, bus.hi_we, bus.lo_we); end
        total++; if (bus.quotient !== '0 || bus.remainder !== '0) begin bad++; $display("FAIL rst_mid results got=%h/%h want=0/0", bus.quotient, bus.remainder); end
        next_cycle();
        observe(40, 1'b1, cnt, at, se, gap, we, hld, q, r);
        total++; if (cnt !== 0 || se !== -1) begin bad++; $display("FAIL rst_after ready_cnt=%0d stall_end=%0d want=0/-1", cnt, se); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
